// File: rtl/motor_step_sequencer.sv
// rtl/motor_step_sequencer.sv - Avalon-MM stepper-motor sequencer driving 4 coil phases plus enable.
// Firmware programs direction, step rate and step count; the block sequences the coils itself.
module motor_step_sequencer #(
  parameter int PERIOD_W       = 24,
  parameter int STEP_W         = 16,
  parameter int DEFAULT_PERIOD = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [4:0]  out_port,
  output logic        irq
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [4:0]          ctrl_q, ctrl_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic [2:0]          idx_q, idx_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [4:0]          out_q, out_d;
  logic                irq_q, irq_d;
  logic                wr;
  logic [2:0]          delta;
  logic                unused_wdata;

  assign unused_wdata = &{1'b0, writedata[31:PERIOD_W]};
  assign wr           = chipselect & ~write_n;
  assign delta        = ctrl_q[2] ? 3'd1 : 3'd2;

  function automatic logic [3:0] phase(input logic [2:0] i);
    case (i)
      3'd0:    phase = 4'b0001;
      3'd1:    phase = 4'b0011;
      3'd2:    phase = 4'b0010;
      3'd3:    phase = 4'b0110;
      3'd4:    phase = 4'b0100;
      3'd5:    phase = 4'b1100;
      3'd6:    phase = 4'b1000;
      default: phase = 4'b1001;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      period_q <= PERIOD_W'(DEFAULT_PERIOD);
      steps_q  <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      out_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      period_q <= period_d;
      steps_q  <= steps_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      out_q    <= out_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    period_d = period_q;
    steps_d  = steps_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    done_d   = done_q;

    if (wr && address == 2'd1) begin
      period_d = (writedata[PERIOD_W-1:0] < PERIOD_W'(2)) ? PERIOD_W'(2) : writedata[PERIOD_W-1:0];
    end
    if (wr && address == 2'd3 && writedata[1]) begin
      done_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (wr && address == 2'd2) begin
          steps_d = writedata[STEP_W-1:0];
        end
        if (wr && address == 2'd0) begin
          ctrl_d = writedata[4:0];
          if (writedata[0] && steps_q != '0) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            ctrl_d[0] = 1'b0;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + PERIOD_W'(1);
        if (wr && address == 2'd0 && !writedata[0]) begin
          ctrl_d  = writedata[4:0];
          state_d = IDLE;
        end else begin
          if (wr && address == 2'd0) begin
            ctrl_d = writedata[4:0];
          end
          // >= so a PERIOD shrunk below the running count steps at once instead of wrapping
          if (cnt_q >= period_q - PERIOD_W'(1)) begin
            cnt_d   = '0;
            idx_d   = ctrl_q[1] ? idx_q - delta : idx_q + delta;
            steps_d = steps_q - STEP_W'(1);
            if (steps_q == STEP_W'(1)) begin
              state_d   = IDLE;
              done_d    = 1'b1;
              ctrl_d[0] = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The edge that takes the last step still shows that step's phase; IDLE rules apply afterwards.
  always_comb begin
    out_d = '0;
    if (state_q == RUN || ctrl_d[4]) begin
      out_d = {1'b1, phase(idx_d)};
    end
    irq_d = done_q & ctrl_q[3];
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata = {27'd0, ctrl_q};
      2'd1:    readdata = {{(32-PERIOD_W){1'b0}}, period_q};
      2'd2:    readdata = {{(32-STEP_W){1'b0}}, steps_q};
      default: readdata = {25'd0, idx_q, 2'b00, done_q, state_q == RUN};
    endcase
  end

  assign out_port = out_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_motor_step_sequencer.sv
// tb/tb_motor_step_sequencer.sv - scoreboard bench for motor_step_sequencer.
module tb_motor_step_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [4:0]  out_port;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int         cyc;
    logic [4:0] val;
  } exp_t;
  exp_t sb[$];

  motor_step_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] tbl(input int i);
    case (i)
      0: tbl = 4'b0001;
      1: tbl = 4'b0011;
      2: tbl = 4'b0010;
      3: tbl = 4'b0110;
      4: tbl = 4'b0100;
      5: tbl = 4'b1100;
      6: tbl = 4'b1000;
      default: tbl = 4'b1001;
    endcase
  endfunction

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1 d = readdata;
    chipselect = 1'b0;
    vectors++;
    if (d !== exp) begin
      miscompares++;
      $display("FAIL %s: read 0x%08h, expected 0x%08h", name, d, exp);
    end
  endtask

  task automatic check_pin(input string name, input logic [4:0] got, input logic [4:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  // Expected out_port after each edge following the start write, for ncyc edges.
  task automatic push_run(input int p, input int n, input int start, input int dir,
                          input int half, input int hold, input int ncyc);
    for (int i = 1; i <= ncyc; i++) begin
      exp_t e;
      int   k;
      int   idx;
      k = (i / p < n) ? i / p : n;
      idx = start + (dir != 0 ? -1 : 1) * k * (half != 0 ? 1 : 2);
      idx = ((idx % 8) + 8) % 8;
      e.cyc = i;
      if (i <= n * p || hold != 0) e.val = {1'b1, tbl(idx)};
      else e.val = 5'd0;
      sb.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc > 5000) begin
        miscompares++;
        $display("FAIL %s: scoreboard not drained, %0d left", name, sb.size());
        sb.delete();
      end else if (sb[0].cyc == cyc) begin
        exp_t e;
        e = sb.pop_front();
        vectors++;
        if (out_port !== e.val) begin
          miscompares++;
          $display("FAIL %s cycle %0d: out_port 0x%02h, expected 0x%02h", name, cyc, out_port, e.val);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_pin("reset_out_port", out_port, 5'd0);
    check_pin("reset_irq", {4'd0, irq}, 5'd0);
    rd_check("reset_ctrl", 2'd0, 32'd0);
    rd_check("reset_period", 2'd1, 32'd50000);
    rd_check("reset_steps", 2'd2, 32'd0);
    rd_check("reset_status", 2'd3, 32'd0);
  endtask

  task automatic test_half_step();
    do_reset();
    wr(2'd1, 32'd4);
    wr(2'd2, 32'd3);
    wr(2'd0, 32'h05);
    push_run(4, 3, 0, 0, 1, 0, 16);
    drain("half_step");
    rd_check("half_steps_left", 2'd2, 32'd0);
    rd_check("half_status", 2'd3, 32'h32);
    rd_check("half_ctrl_run_cleared", 2'd0, 32'h04);
  endtask

  task automatic test_reverse_irq();
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd2, 32'd2);
    wr(2'd0, 32'h0B);
    push_run(2, 2, 0, 1, 0, 0, 4);
    drain("reverse");
    check_pin("irq_latency_low", {4'd0, irq}, 5'd0);
    @(posedge clk); #1;
    check_pin("irq_set", {4'd0, irq}, 5'd1);
    wr(2'd3, 32'h2);
    check_pin("irq_held_one_cycle", {4'd0, irq}, 5'd1);
    @(posedge clk); #1;
    check_pin("irq_cleared", {4'd0, irq}, 5'd0);
    rd_check("reverse_status", 2'd3, 32'h40);
  endtask

  task automatic test_wrap();
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd2, 32'd10);
    wr(2'd0, 32'h05);
    push_run(2, 10, 0, 0, 1, 0, 23);
    drain("wrap");
    rd_check("wrap_status", 2'd3, 32'h22);
  endtask

  task automatic test_abort_resume();
    do_reset();
    wr(2'd1, 32'd10);
    wr(2'd2, 32'd100);
    wr(2'd0, 32'h01);
    push_run(10, 100, 0, 0, 0, 0, 54);
    drain("pre_abort");
    wr(2'd2, 32'd7);
    check_pin("steps_write_ignored_in_run", out_port, {1'b1, tbl(2)});
    wr(2'd0, 32'h00);
    check_pin("abort_edge", out_port, {1'b1, tbl(2)});
    @(posedge clk); #1;
    check_pin("abort_idle", out_port, 5'd0);
    rd_check("abort_steps", 2'd2, 32'd95);
    rd_check("abort_status", 2'd3, 32'h20);
    wr(2'd0, 32'h11);
    push_run(10, 95, 2, 0, 0, 1, 25);
    drain("resume");
    rd_check("resume_busy", 2'd3, 32'h61);
  endtask

  task automatic test_period_min_zero_steps();
    do_reset();
    wr(2'd1, 32'd0);
    rd_check("period_zero_clamp", 2'd1, 32'd2);
    wr(2'd1, 32'd1);
    rd_check("period_one_clamp", 2'd1, 32'd2);
    wr(2'd1, 32'd3);
    rd_check("period_three", 2'd1, 32'd3);
    wr(2'd0, 32'h01);
    rd_check("zero_steps_status", 2'd3, 32'd0);
    rd_check("zero_steps_ctrl", 2'd0, 32'd0);
    check_pin("zero_steps_out", out_port, 5'd0);
  endtask

  task automatic test_period_shrink_reset();
    do_reset();
    wr(2'd1, 32'd1000);
    wr(2'd2, 32'd5);
    wr(2'd0, 32'h05);
    repeat (500) @(posedge clk);
    wr(2'd1, 32'd10);
    check_pin("shrink_before_step", out_port, 5'h11);
    @(posedge clk); #1;
    check_pin("shrink_immediate_step", out_port, 5'h13);
    repeat (9) @(posedge clk);
    #1;
    check_pin("shrink_hold", out_port, 5'h13);
    @(posedge clk); #1;
    check_pin("shrink_next_step", out_port, 5'h12);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check_pin("midrun_reset_out", out_port, 5'd0);
    @(negedge clk) reset = 1'b0;
    rd_check("midrun_reset_status", 2'd3, 32'd0);
    rd_check("midrun_reset_period", 2'd1, 32'd50000);
  endtask

  initial begin
    test_reset();
    test_half_step();
    test_reverse_irq();
    test_wrap();
    test_abort_resume();
    test_period_min_zero_steps();
    test_period_shrink_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/motor_step_sequencer.md
Name: motor_step_sequencer

Overview:
- Avalon-MM slave stepper-motor controller.
- Generates the 4-phase coil pattern plus a driver-enable bit on a 5-bit out_port, so firmware only programs direction, step rate and step count.
- Sits beside the CPU on the system interconnect and drives the motor driver pins directly. It replaces per-step software writes to a plain output port.

Parameters:
PERIOD_W, 24, width of step-period register (clock cycles per step)
STEP_W, 16, width of step-count register
DEFAULT_PERIOD, 50000, reset value of PERIOD

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
address  in  2  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  combinational read mux, zero-extended
out_port  out  5  [3:0] coil phases A,B,C,D; [4] driver enable
irq  out  1  level interrupt, = done & irq_en

Behaviour:
- One clock (clk). Reset is synchronous and active-high. Write = chipselect & ~write_n. Reads have no side effects.
- Registers:
  - addr0 CTRL: [0] run, [1] dir (0 = idx+, 1 = idx-), [2] half (1 = half-step), [3] irq_en, [4] hold (energize coils while idle).
  - addr1 PERIOD: [PERIOD_W-1:0]. A written value < 2 is stored as 2.
  - addr2 STEPS: write loads steps_rem. Read returns live steps_rem.
  - addr3 STATUS: [0] busy, [1] done (sticky; write 1 to bit1 clears it), [6:4] idx. Other bits read 0.
- Reset values: CTRL = 0, PERIOD = DEFAULT_PERIOD, steps_rem = 0, idx = 0, cnt = 0, done = 0, busy = 0, out_port = 0, irq = 0.
- Phase table, idx 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001.
- FSM states: IDLE, RUN.
- IDLE:
  - out_port[3:0] = hold ? table[idx] : 0; out_port[4] = hold.
  - A CTRL write with run = 1 and steps_rem != 0 enters RUN on the next edge, clears cnt, and sets busy.
  - A CTRL write with run = 1 and steps_rem = 0 is ignored for motion; the run bit reads back 0.
- RUN:
  - out_port = {1'b1, table[idx]}.
  - cnt increments every cycle. At cnt >= PERIOD-1: cnt <= 0, idx <= idx ± (half ? 1 : 2) mod 8, steps_rem <= steps_rem - 1.
  - If steps_rem was 1 at that step: go to IDLE, set done, clear busy, clear the run bit.
  - Step k (k = 1..N) updates out_port exactly k*PERIOD cycles after the start write cycle.
- Abort: a CTRL write with run = 0 during RUN returns to IDLE next edge. steps_rem and idx are retained; done is not set.
- Writes during RUN:
  - STEPS is ignored.
  - PERIOD takes effect immediately. Using >= in the compare guarantees a reduced PERIOD never stalls the counter.
  - dir, half and irq_en written to CTRL while run stays 1 take effect at the next step.
- Wrap-around: idx wraps 7→0 and 0→7.
- In full-step mode an odd idx stays odd (two-coil drive); an even idx stays even (one-coil drive).
- Simultaneous done set and W1C in the same cycle: set wins.
- Reset mid-RUN forces all reset values on the next edge. Coils de-energize with out_port = 0.
- irq is registered with 1-cycle latency from the done/irq_en change.

Test Plan:
1. Reset -> out_port = 0, readdata(PERIOD) = 50000, STATUS = 0, irq = 0.
2. PERIOD = 4, STEPS = 3, CTRL = 0x05 (run, half, dir+) -> out_port goes 0x11 → 0x13 → 0x12 → 0x16 at 4, 8, 12 cycles; then idle, out_port = 0, done = 1, STEPS reads 0.
3. idx = 0, full-step, dir = 1, PERIOD = 2, STEPS = 2, irq_en = 1 -> idx goes 6 then 4; phases 1000 then 0100; irq = 1; writing STATUS = 0x2 drops irq next cycle.
4. STEPS = 100, run started, CTRL = 0 written after 5 steps -> IDLE, STEPS reads 95, done = 0. Then CTRL = 0x11 (run, hold) resumes from the retained idx.
5. Write PERIOD = 0 -> reads back 2. STEPS = 0 with run = 1 -> busy stays 0, CTRL[0] reads 0.
6. PERIOD = 1000, run; at cnt = 500 write PERIOD = 10 -> next step on the following cycle, then every 10 cycles. Reset asserted mid-run -> out_port = 0 next edge.
